mcpu_prog_loader: RTL and testbench
===================================

Name: mcpu_prog_loader

Overview:
- Hardware program loader and dumper for the multicycle CPU's unified instruction/data RAM.
- Generalises the bench-side memory clear, program load and memory dump into a parametrised synthesizable engine with CLEAR, LOAD and DUMP commands over valid/ready streams.
- Holds the CPU via cpu_hold while it owns the RAM port.
- Sits between the host/debug link and the RAM write/read port, muxed in front of the CPU's RAM port.

Parameters:
- WORD_SIZE, 16, instruction/data word width (4-bit opcode + three 4-bit operand fields at default).
- ADDR_WIDTH, 8, RAM address width.
- RAM_SIZE, 256, number of RAM words; must be <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 CLEAR, 01 LOAD, 10 DUMP, 11 reserved.
- cmd_base  in  ADDR_WIDTH  first RAM address.
- cmd_len  in  ADDR_WIDTH+1  word count, 0..RAM_SIZE.
- in_valid  in  1  load-word valid.
- in_ready  out  1  high only in LOAD.
- in_data  in  WORD_SIZE  load word.
- out_valid  out  1  dump-word valid.
- out_ready  in  1  dump-word accept.
- out_data  out  WORD_SIZE  dump word (registered).
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_WIDTH  RAM address (registered pointer).
- mem_wdata  out  WORD_SIZE  RAM write data.
- mem_rdata  in  WORD_SIZE  RAM read data, valid 1 cycle after mem_addr.
- cpu_hold  out  1  holds CPU in reset while high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky command error.

Behaviour:
- Reset: state IDLE.
  - Registered outputs after the reset edge: out_valid=0, out_data=0, mem_addr=0, done=0, err=0, busy=0, cpu_hold=1.
  - Derived outputs: cmd_ready=1, in_ready=0, mem_we=0.
  - Reset during any operation aborts it at the next edge; partial RAM contents are left as written.
- States: IDLE, CLEAR, LOAD, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE.
- Command accept (cmd_valid && cmd_ready):
  - Latch base into mem_addr and len into the remaining-word counter.
  - Clear err; set cpu_hold=1.
- Error check at accept: cmd_op=11, or cmd_base+cmd_len > RAM_SIZE (computed at ADDR_WIDTH+2 bits).
  - Result: err=1, go to DONE, no memory access, cpu_hold stays 1.
- cmd_len=0 (valid op): go directly to DONE; done is high the cycle after accept.
- CLEAR:
  - mem_we=1 and mem_wdata=0 every cycle; mem_addr increments each cycle.
  - Exactly len cycles, then DONE.
- LOAD:
  - in_ready=1.
  - mem_we = in_valid, combinational; mem_wdata = in_data.
  - Each handshake writes at mem_addr, then increments the pointer and decrements the counter.
  - The last handshake moves to DONE.
  - in_valid low stalls indefinitely with no timeout.
- DUMP:
  - DUMP_RD presents mem_addr.
  - DUMP_CAP latches mem_rdata into out_data.
  - DUMP_OUT holds out_valid=1 with out_data stable until out_ready.
  - On handshake: pointer+1, counter-1, then back to DUMP_RD, or to DONE if the counter reaches 0.
  - out_valid drops the cycle after the handshake; minimum 3 cycles per word.
- DONE:
  - One cycle with done=1 and cmd_ready=0, then IDLE.
  - A successful LOAD (including len 0) clears cpu_hold on this transition.
  - CLEAR and DUMP leave cpu_hold=1.
- in_valid outside LOAD and out_ready outside DUMP_OUT are ignored.
- Addresses never wrap; the range check guarantees this.
- mem_we is never high outside CLEAR and LOAD.

Optional Feature:
- Macro: MCPU_LOADER_CHECKSUM_EN.
- When defined, adds output port csum (WORD_SIZE bits):
  - Modulo-2^WORD_SIZE sum of every word written by LOAD or emitted by DUMP in the current command.
  - Cleared to 0 on reset and on command accept.
  - Final value is stable from the done pulse until the next accept.
  - CLEAR leaves it at 0.
- When undefined, no port and no adder logic.

Test Plan:
- Reset, then LOAD base 0 len 3 with words 0x1E2C, 0x1F27, 0x2E04 -> mem_we at addresses 0, 1, 2 with those words; done one cycle after the last write; cpu_hold 1 -> 0; err=0.
- DUMP base 0 len 3, out_ready low for 2 cycles on the second word -> out_data sequence 0x1E2C, 0x1F27, 0x2E04; out_valid and out_data stable during the stall; mem_we stays 0; cpu_hold=1 throughout.
- CLEAR base 250 len 6 -> mem_we=1 with wdata 0 at 250..255 on 6 consecutive cycles. Then LOAD base 250 len 7 -> err=1, no mem_we, done pulse, in_ready never high.
- LOAD len 0 -> done the cycle after accept; no writes; cpu_hold clears; cmd_op=11 -> err=1 with a done pulse.
- Reset asserted after 2 of 4 LOAD handshakes -> next cycle in IDLE with cmd_ready=1, in_ready=0, cpu_hold=1, err=0; the 2 words written stay in RAM.
- With MCPU_LOADER_CHECKSUM_EN: LOAD 0x0001, 0xFFFF, 0x0003 -> csum=0x0003 at done; a following DUMP of the same range also gives 0x0003.

Source files
------------

// File: rtl/mcpu_prog_loader.sv
// Program loader/dumper: CLEAR, LOAD and DUMP engine for the CPU's unified RAM.
// Ports: cmd stream, in (load) and out (dump) streams, RAM port, cpu_hold/busy/done/err; csum with MCPU_LOADER_CHECKSUM_EN.
module mcpu_prog_loader #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_SIZE   = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_SIZE-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_SIZE-1:0]  out_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
`ifdef MCPU_LOADER_CHECKSUM_EN
  output logic [WORD_SIZE-1:0]  csum,
`endif
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DUMP_RD,
    S_DUMP_CAP,
    S_DUMP_OUT,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [ADDR_WIDTH+1:0] LP_SIZE = (ADDR_WIDTH+2)'(RAM_SIZE);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [WORD_SIZE-1:0]  r_out;
  logic [1:0]            r_op;
  logic                  r_err;
  logic                  r_hold;

  logic [ADDR_WIDTH+1:0] w_end;
  logic                  w_bad;
  logic                  w_len0;
  logic                  w_last;
  logic                  w_step;

  assign w_end  = {2'b00, cmd_base} + {1'b0, cmd_len};
  assign w_bad  = (cmd_op == OP_RSVD) || (w_end > LP_SIZE);
  assign w_len0 = (cmd_len == '0);
  assign w_last = (r_cnt == (ADDR_WIDTH+1)'(1));

  assign mem_addr  = r_addr;
  assign out_data  = r_out;
  assign out_valid = (r_state == S_DUMP_OUT);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign cpu_hold  = r_hold;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    w_step    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (w_bad || w_len0) begin
            w_next = S_DONE;
          end else begin
            unique case (cmd_op)
              OP_CLEAR: w_next = S_CLEAR;
              OP_LOAD:  w_next = S_LOAD;
              OP_DUMP:  w_next = S_DUMP_RD;
              default:  w_next = S_DONE;
            endcase
          end
        end
      end
      S_CLEAR: begin
        mem_we = 1'b1;
        w_step = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_LOAD: begin
        in_ready  = 1'b1;
        mem_we    = in_valid;
        mem_wdata = in_data;
        w_step    = in_valid;
        if (in_valid && w_last) w_next = S_DONE;
      end
      S_DUMP_RD:  w_next = S_DUMP_CAP;
      S_DUMP_CAP: w_next = S_DUMP_OUT;
      S_DUMP_OUT: begin
        w_step = out_ready;
        if (out_ready) w_next = w_last ? S_DONE : S_DUMP_RD;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pointer stays on the final word so it never wraps past the top of RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
      r_op   <= OP_CLEAR;
      r_err  <= 1'b0;
      r_hold <= 1'b1;
    end else begin
      if (r_state == S_IDLE && cmd_valid) begin
        r_addr <= cmd_base;
        r_cnt  <= cmd_len;
        r_op   <= cmd_op;
        r_err  <= w_bad;
        r_hold <= 1'b1;
      end
      if (w_step) begin
        r_cnt <= r_cnt - (ADDR_WIDTH+1)'(1);
        if (!w_last) r_addr <= r_addr + ADDR_WIDTH'(1);
      end
      if (r_state == S_DUMP_CAP) r_out <= mem_rdata;
      // Only a clean LOAD releases the CPU.
      if (r_state == S_DONE && r_op == OP_LOAD && !r_err) r_hold <= 1'b0;
    end
  end

`ifdef MCPU_LOADER_CHECKSUM_EN
  logic [WORD_SIZE-1:0] r_csum;
  assign csum = r_csum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_csum <= '0;
    end else if (r_state == S_IDLE && cmd_valid) begin
      r_csum <= '0;
    end else if (r_state == S_LOAD && in_valid) begin
      r_csum <= r_csum + in_data;
    end else if (r_state == S_DUMP_OUT && out_ready) begin
      r_csum <= r_csum + r_out;
    end
  end
`endif

endmodule

// File: tb/tb_mcpu_prog_loader.sv
// Directed bench for mcpu_prog_loader with a behavioural 256-word RAM.
// Covers reset, LOAD, DUMP with stall, CLEAR, range/op errors, len 0, reset abort.
module tb_mcpu_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_base = 8'd0;
  logic [8:0]  cmd_len = 9'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
`ifdef MCPU_LOADER_CHECKSUM_EN
  logic [15:0] csum;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] ram [256];
  logic        ram_init = 1'b0;

  mcpu_prog_loader dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef MCPU_LOADER_CHECKSUM_EN
    .csum(csum),
`endif
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 16'hAAAA;
      ram_init <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] b,
                       input logic [8:0] l);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_base  = b;
    cmd_len   = l;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL rst_out_data got %h want 0000", out_data); end
    n_cmp++; if (mem_addr !== 8'h0) begin n_bad++; $display("FAIL rst_mem_addr got %h want 00", mem_addr); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_hold got %b want 1", cpu_hold); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
  endtask

  task automatic test_load();
    logic [15:0] lw [3];
    lw[0] = 16'h1E2C; lw[1] = 16'h1F27; lw[2] = 16'h2E04;
    issue(2'b01, 8'd0, 9'd3);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL load_in_ready got %b want 1", in_ready); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL load_cmd_ready got %b want 0", cmd_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL load_busy got %b want 1", busy); end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        in_valid = 1'b0;
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL load_stall_we got %b want 0", mem_we); end
        step();
      end
      in_valid = 1'b1;
      in_data  = lw[i];
      #1;
      n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL load_we[%0d] got %b want 1", i, mem_we); end
      n_cmp++; if (mem_addr !== 8'(i)) begin n_bad++; $display("FAIL load_addr[%0d] got %h want %h", i, mem_addr, 8'(i)); end
      n_cmp++; if (mem_wdata !== lw[i]) begin n_bad++; $display("FAIL load_wdata[%0d] got %h want %h", i, mem_wdata, lw[i]); end
      n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL load_hold[%0d] got %b want 1", i, cpu_hold); end
      step();
    end
    in_valid = 1'b0;
    #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL load_done got %b want 1", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL load_err got %b want 0", err); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL load_done_cmd_ready got %b want 0", cmd_ready); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL load_done_in_ready got %b want 0", in_ready); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL load_done_pulse got %b want 0", done); end
    n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL load_release got %b want 0", cpu_hold); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ram[i] !== lw[i]) begin n_bad++; $display("FAIL load_ram[%0d] got %h want %h", i, ram[i], lw[i]); end
    end
  endtask

  task automatic test_dump();
    logic [15:0] dw [3];
    int k;
    dw[0] = 16'h1E2C; dw[1] = 16'h1F27; dw[2] = 16'h2E04;
    issue(2'b10, 8'd0, 9'd3);
    out_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      k = 0;
      while (out_valid !== 1'b1 && k < 8) begin
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL dump_we got %b want 0", mem_we); end
        n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL dump_hold got %b want 1", cpu_hold); end
        step();
        k++;
      end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL dump_timeout[%0d] got out_valid %b want 1", w, out_valid); end
      n_cmp++; if (out_data !== dw[w]) begin n_bad++; $display("FAIL dump_data[%0d] got %h want %h", w, out_data, dw[w]); end
      if (w == 1) begin
        repeat (2) begin
          step();
          n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL dump_stall_valid got %b want 1", out_valid); end
          n_cmp++; if (out_data !== dw[1]) begin n_bad++; $display("FAIL dump_stall_data got %h want %h", out_data, dw[1]); end
          n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL dump_stall_we got %b want 0", mem_we); end
        end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dump_drop[%0d] got %b want 0", w, out_valid); end
    end
    #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL dump_done got %b want 1", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL dump_err got %b want 0", err); end
    step();
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL dump_hold_end got %b want 1", cpu_hold); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL dump_idle got %b want 1", cmd_ready); end
  endtask

  task automatic test_clear_range();
    issue(2'b00, 8'd250, 9'd6);
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL clr_we[%0d] got %b want 1", i, mem_we); end
      n_cmp++; if (mem_wdata !== 16'h0) begin n_bad++; $display("FAIL clr_wdata[%0d] got %h want 0000", i, mem_wdata); end
      n_cmp++; if (mem_addr !== 8'(250 + i)) begin n_bad++; $display("FAIL clr_addr[%0d] got %0d want %0d", i, mem_addr, 250 + i); end
      step();
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL clr_done got %b want 1", done); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL clr_done_we got %b want 0", mem_we); end
    step();
    n_cmp++; if (ram[255] !== 16'h0) begin n_bad++; $display("FAIL clr_ram255 got %h want 0000", ram[255]); end
    n_cmp++; if (ram[250] !== 16'h0) begin n_bad++; $display("FAIL clr_ram250 got %h want 0000", ram[250]); end
    n_cmp++; if (ram[249] !== 16'hAAAA) begin n_bad++; $display("FAIL clr_ram249 got %h want aaaa", ram[249]); end
    in_valid = 1'b1;
    in_data  = 16'h5555;
    issue(2'b01, 8'd250, 9'd7);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL range_err got %b want 1", err); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL range_done got %b want 1", done); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL range_in_ready got %b want 0", in_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL range_we got %b want 0", mem_we); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL range_sticky got %b want 1", err); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL range_hold got %b want 1", cpu_hold); end
    n_cmp++; if (ram[250] !== 16'h0) begin n_bad++; $display("FAIL range_ram250 got %h want 0000", ram[250]); end
  endtask

  task automatic test_len0_op3();
    issue(2'b01, 8'd5, 9'd0);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL len0_done got %b want 1", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL len0_err got %b want 0", err); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL len0_we got %b want 0", mem_we); end
    step();
    n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL len0_release got %b want 0", cpu_hold); end
    n_cmp++; if (ram[5] !== 16'hAAAA) begin n_bad++; $display("FAIL len0_ram got %h want aaaa", ram[5]); end
    issue(2'b11, 8'd0, 9'd1);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL op3_done got %b want 1", done); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL op3_err got %b want 1", err); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL op3_hold got %b want 1", cpu_hold); end
    step();
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL op3_hold_end got %b want 1", cpu_hold); end
  endtask

  task automatic test_reset_abort();
    issue(2'b01, 8'd20, 9'd4);
    in_valid = 1'b1;
    in_data  = 16'h1111;
    step();
    in_data  = 16'h2222;
    step();
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL abort_cmd_ready got %b want 1", cmd_ready); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL abort_in_ready got %b want 0", in_ready); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL abort_hold got %b want 1", cpu_hold); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL abort_err got %b want 0", err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
    n_cmp++; if (ram[20] !== 16'h1111) begin n_bad++; $display("FAIL abort_ram20 got %h want 1111", ram[20]); end
    n_cmp++; if (ram[21] !== 16'h2222) begin n_bad++; $display("FAIL abort_ram21 got %h want 2222", ram[21]); end
    n_cmp++; if (ram[22] !== 16'hAAAA) begin n_bad++; $display("FAIL abort_ram22 got %h want aaaa", ram[22]); end
  endtask

`ifdef MCPU_LOADER_CHECKSUM_EN
  task automatic test_csum();
    logic [15:0] cw [3];
    int k;
    cw[0] = 16'h0001; cw[1] = 16'hFFFF; cw[2] = 16'h0003;
    issue(2'b01, 8'd100, 9'd3);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = cw[i];
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (csum !== 16'h0003) begin n_bad++; $display("FAIL csum_load got %h want 0003", csum); end
    step();
    issue(2'b10, 8'd100, 9'd3);
    out_ready = 1'b1;
    k = 0;
    while (done !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    out_ready = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL csum_dump_timeout got done %b want 1", done); end
    n_cmp++; if (csum !== 16'h0003) begin n_bad++; $display("FAIL csum_dump got %h want 0003", csum); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_dump();
    test_clear_range();
    test_len0_op3();
    test_reset_abort();
`ifdef MCPU_LOADER_CHECKSUM_EN
    test_csum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
